// File: rtl/logic_accum_unit.sv
// rtl/logic_accum_unit.sv - registered eight-function bitwise logic unit with optional accumulator
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      input handshake for a, b, op, acc_mode
//   a, b                     WIDTH-bit operands (b unused when acc_mode=1)
//   op                       0 AND, 1 OR, 2 NOT a, 3 NOR, 4 XOR, 5 NAND, 6 XNOR, 7 PASS a
//   acc_mode                 take B from the accumulator and write the result back to it
//   acc_clear                load ACC_INIT into the accumulator on the next edge
//   out_valid / out_ready    output handshake for result, zero, parity
//   result, zero, parity     registered function output and its flags
//   acc                      current accumulator value

module logic_accum_unit #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [WIDTH-1:0] acc
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    logic             accept;
    logic             deliver;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] func_out;

    // The result slot frees up in the same cycle it is drained, so a new
    // operand can enter every cycle while downstream keeps up.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign operand_b = acc_mode ? acc : b;

    always_comb begin
        func_out = '0;
        case (op)
            OP_AND:  func_out = a & operand_b;
            OP_OR:   func_out = a | operand_b;
            OP_NOTA: func_out = ~a;
            OP_NOR:  func_out = ~(a | operand_b);
            OP_XOR:  func_out = a ^ operand_b;
            OP_NAND: func_out = ~(a & operand_b);
            OP_XNOR: func_out = ~(a ^ operand_b);
            OP_PASS: func_out = a;
            default: func_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= func_out;
            zero      <= (func_out == '0);
            parity    <= ^func_out;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    // Clear takes priority over write-back; the op itself already used the
    // pre-clear accumulator through operand_b.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= ACC_INIT;
        end else if (acc_clear) begin
            acc <= ACC_INIT;
        end else if (accept && acc_mode) begin
            acc <= func_out;
        end
    end

endmodule

// File: tb/tb_logic_accum_unit.sv
// tb/tb_logic_accum_unit.sv - self-checking bench for logic_accum_unit against a truth-table model

module tb_logic_accum_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         acc_mode = 1'b0;
    logic         acc_clear = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         parity;
    logic [W-1:0] acc;

    logic_accum_unit #(.WIDTH(W), .ACC_INIT('0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clear(acc_clear),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .parity(parity), .acc(acc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Gate functions as 2-input truth tables, bit index = {a_bit, b_bit}.
    logic [3:0] truth [8];

    // Reference state: pending result slot and accumulator.
    logic         m_valid = 1'b0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_acc = '0;
    logic         seen_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] gate(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic [3:0]   t;
        t = truth[f];
        for (int i = 0; i < W; i++) r[i] = t[{x[i], y[i]}];
        return r;
    endfunction

    function automatic logic xor_all(input logic [W-1:0] v);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(v[i]);
        return logic'(ones % 2);
    endfunction

    // One clock: drive at the falling edge, check in_ready before the rising
    // edge, advance the model on the edge, check registered outputs after it.
    task automatic step(input logic rst, input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2:0] ov, input logic am, input logic ac, input logic ordy);
        logic         take;
        logic [W-1:0] f;
        reset = rst; in_valid = iv; a = av; b = bv; op = ov;
        acc_mode = am; acc_clear = ac; out_ready = ordy;
        #1;
        seen_ready = in_ready;
        if (!rst) check("in_ready", in_ready, !m_valid || ordy);
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_result = '0; m_acc = '0;
        end else begin
            take = iv && (!m_valid || ordy);
            f = gate(ov, av, am ? m_acc : bv);
            if (take) begin
                m_valid = 1'b1; m_result = f;
                if (am) m_acc = f;
            end else if (m_valid && ordy) begin
                m_valid = 1'b0;
            end
            if (ac) m_acc = '0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("result", result, m_result);
        check("zero", zero, m_result == '0);
        check("parity", parity, xor_all(m_result));
        check("acc", acc, m_acc);
        @(negedge clk);
    endtask

    logic [W-1:0] sweep_exp [8];

    initial begin
        truth[0] = 4'b1000; truth[1] = 4'b1110; truth[2] = 4'b0011; truth[3] = 4'b0001;
        truth[4] = 4'b0110; truth[5] = 4'b0111; truth[6] = 4'b1001; truth[7] = 4'b1100;
        sweep_exp[0] = 16'hF000; sweep_exp[1] = 16'hFFF0; sweep_exp[2] = 16'h0F0F; sweep_exp[3] = 16'h000F;
        sweep_exp[4] = 16'h0FF0; sweep_exp[5] = 16'h0FFF; sweep_exp[6] = 16'hF00F; sweep_exp[7] = 16'hF0F0;

        // Reset for two cycles, then observe the idle state.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 16'h0000);
        check("rst_zero", zero, 1);
        check("rst_parity", parity, 0);
        check("rst_acc", acc, 16'h0000);
        check("rst_in_ready", in_ready, 1);

        // Op sweep at full throughput.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 16'hF0F0, 16'hFF00, 3'(i), 0, 0, 1);
            check("sweep_result", result, sweep_exp[i]);
            check("sweep_valid", out_valid, 1);
            check("sweep_parity", parity, 0);
        end

        // Accumulator chain.
        step(0, 1, 16'h00FF, 16'(16'($urandom)), 1, 1, 0, 1);
        check("chain_or_acc", acc, 16'h00FF);
        step(0, 1, 16'h0F0F, 16'(16'($urandom)), 4, 1, 0, 1);
        check("chain_xor_acc", acc, 16'h0FF0);
        check("chain_xor_res", result, 16'h0FF0);
        step(0, 1, 16'h0F00, 16'(16'($urandom)), 0, 1, 0, 1);
        check("chain_and_acc", acc, 16'h0F00);
        check("chain_and_zero", zero, 0);

        // Backpressure: drain, accept with out_ready low, stall three cycles.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 16'h1234, 16'hFFFF, 0, 0, 0, 0);
        check("bp_accept", result, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 16'h5555, 16'h0000, 7, 0, 0, 0);
            check("bp_hold", result, 16'h1234);
            check("bp_in_ready", seen_ready, 0);
        end
        step(0, 1, 16'h5555, 16'h0000, 7, 0, 0, 1);
        check("bp_release_ready", seen_ready, 1);
        check("bp_release_result", result, 16'h5555);
        check("bp_release_valid", out_valid, 1);

        // Clear coinciding with an accumulator op.
        step(0, 1, 16'h0F0F, 0, 7, 1, 0, 1);
        step(0, 1, 16'h00FF, 0, 4, 1, 1, 1);
        check("clr_result", result, 16'h0FF0);
        check("clr_acc", acc, 16'h0000);

        // Reset while a result is stalled.
        step(0, 1, 16'hABCD, 0, 7, 1, 0, 1);
        step(0, 1, 16'h1111, 0, 7, 0, 0, 0);
        check("pre_rst_result", result, 16'hABCD);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_acc", acc, 16'h0000);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("midrst_no_deliver", out_valid, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), logic'($urandom_range(0, 3) != 0),
                 16'($urandom), 16'($urandom), 3'($urandom), logic'($urandom),
                 ($urandom_range(0, 7) == 0), logic'($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_accum_unit.md
Name: logic_accum_unit

Overview:
- Parametrised, registered successor to the two-input gate primitives: one WIDTH-bit bitwise logic unit with eight selectable gate functions.
- Optional accumulator mode: operand b comes from an internal register, and the result is written back to it.
- Valid/ready handshake on input and output. Sits between register-file/ALU datapath stages; the output is registered for timing closure.

Parameters:
- WIDTH, 16, operand/result/accumulator width in bits (>=1).
- ACC_INIT, 0, accumulator value after reset and after acc_clear (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  input operands/op valid.
- in_ready  output  1  unit can accept input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored when acc_mode=1.
- op  input  3  function select, see Behaviour.
- acc_mode  input  1  1: B := accumulator; result is written to the accumulator.
- acc_clear  input  1  load ACC_INIT into the accumulator (independent of in_valid).
- out_valid  output  1  result register holds an undelivered result.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0, registered with result.
- parity  output  1  XOR-reduction of result, registered with result.
- acc  output  WIDTH  current accumulator value.

Behaviour:
- Reset (synchronous, highest priority):
  - out_valid=0, result=0, zero=1, parity=0, acc=ACC_INIT.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-transaction drops any held result with no output.
- op encoding (bitwise over WIDTH):
  - 0 AND, 1 OR, 2 NOT a (b ignored), 3 NOR.
  - 4 XOR, 5 NAND, 6 XNOR, 7 PASS a.
- Operand B: B = acc_mode ? acc : b.
- Accept: in_valid && in_ready.
- Ready rule: in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no path from in_valid to in_ready.
- On accept:
  - result, zero and parity load the function output on the next edge; out_valid=1.
  - Latency is exactly 1 cycle.
- Deliver: out_valid && out_ready.
  - If deliver and no accept, out_valid goes to 0 next edge.
  - If deliver and accept in the same cycle, out_valid stays 1 with the new result. This gives full throughput of 1 per cycle.
- Stall: when out_valid && !out_ready, result, zero and parity hold stable and in_ready=0.
- Accumulator:
  - On accept with acc_mode=1, acc loads the function output on the same edge as result.
  - Back-to-back acc_mode ops therefore see the updated acc.
  - acc is not modified by accepts with acc_mode=0.
- acc_clear:
  - Sets acc=ACC_INIT next edge whether or not an input is accepted.
  - If it coincides with an accepted acc_mode op: the op uses the pre-clear acc as B, and result carries that op's output. acc ends at ACC_INIT (clear wins for the accumulator).
- Signals when in_valid=0: a, b, op and acc_mode are don't-care. Output fields only change on accept or reset.
- No X propagation: every register has a defined reset value.

Test Plan:
- WIDTH=16. Reset asserted 2 cycles -> out_valid=0, result=0x0000, zero=1, parity=0, acc=0x0000, in_ready=1.
- Op sweep, out_ready=1, a=0xF0F0, b=0xFF00, ops 0..7 on consecutive cycles.
  - Results one cycle later: 0xF000, 0xFFF0, 0x0F0F, 0x000F, 0x0FF0, 0x0FFF, 0xF00F, 0xF0F0.
  - out_valid held 1 throughout; parity=0 for all.
- Accumulator chain from acc=0:
  - OR a=0x00FF -> acc=0x00FF.
  - XOR a=0x0F0F -> acc=0x0FF0.
  - AND a=0x0F00 -> acc=0x0F00.
  - Result sequence matches; zero=0 each step.
- Backpressure: accept AND 0x1234/0xFFFF, hold out_ready=0 for 3 cycles.
  - result stays 0x1234, in_ready=0, a new in_valid is not accepted.
  - Raise out_ready -> delivered, and the pending input is accepted in the same cycle.
- Simultaneous acc_clear with acc_mode XOR a=0x00FF, acc=0x0F0F -> result=0x0FF0, acc=0x0000 next cycle.
- Reset while out_valid=1 and out_ready=0 with acc=0xABCD -> out_valid=0, acc=0x0000 next cycle; result is never delivered.
